// File: rtl/ber_sweep_pkg.sv
// rtl/ber_sweep_pkg.sv - shared state encoding, default widths and constants for ber_sweep_ctrl
package ber_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_LOCK,
    MEASURE,
    EVAL,
    SELECT,
    RUN,
    FAIL
  } state_e;

  localparam int DEF_N_PHASES     = 4;
  localparam int DEF_NB_PHASE     = 2;
  localparam int DEF_NB_COUNT     = 64;
  localparam int DEF_NB_WINDOW    = 32;
  localparam int DEF_LOCK_TIMEOUT = 2**20;

  localparam logic [DEF_NB_COUNT-1:0] ERR_MAX = {DEF_NB_COUNT{1'b1}};

  function automatic logic is_busy(input state_e s);
    return (s == CLEAR) || (s == WAIT_LOCK) || (s == MEASURE) ||
           (s == EVAL) || (s == SELECT);
  endfunction

endpackage

// File: rtl/ber_min_tracker.sv
// rtl/ber_min_tracker.sv - running minimum of per-phase error counts with lowest-phase tie rule
module ber_min_tracker
  import ber_sweep_pkg::*;
#(
  parameter int NB_PHASE = DEF_NB_PHASE,
  parameter int NB_COUNT = DEF_NB_COUNT
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [NB_COUNT-1:0] i_err,
  input  logic [NB_PHASE-1:0] i_phase,
  output logic [NB_COUNT-1:0] o_best_err,
  output logic [NB_PHASE-1:0] o_best_phase,
  output logic                o_any_ok
);

  logic [NB_COUNT-1:0] best_err_q, best_err_d;
  logic [NB_PHASE-1:0] best_phase_q, best_phase_d;
  logic                any_ok_q, any_ok_d;

  // Strict less-than: a later phase with an equal count never displaces an earlier one.
  always_comb begin
    best_err_d   = best_err_q;
    best_phase_d = best_phase_q;
    any_ok_d     = any_ok_q;
    if (i_clear) begin
      best_err_d   = '1;
      best_phase_d = '0;
      any_ok_d     = 1'b0;
    end else if (i_valid && (i_err < best_err_q)) begin
      best_err_d   = i_err;
      best_phase_d = i_phase;
      any_ok_d     = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      best_err_q   <= '1;
      best_phase_q <= '0;
      any_ok_q     <= 1'b0;
    end else begin
      best_err_q   <= best_err_d;
      best_phase_q <= best_phase_d;
      any_ok_q     <= any_ok_d;
    end
  end

  assign o_best_err   = best_err_q;
  assign o_best_phase = best_phase_q;
  assign o_any_ok     = any_ok_q;

endmodule

// File: rtl/ber_sweep_ctrl.sv
// rtl/ber_sweep_ctrl.sv - PRBS BER phase-sweep sequencer; BER_SWEEP_LOG_EN adds the per-phase error log
module ber_sweep_ctrl
  import ber_sweep_pkg::*;
#(
  parameter int N_PHASES     = DEF_N_PHASES,
  parameter int NB_PHASE     = DEF_NB_PHASE,
  parameter int NB_COUNT     = DEF_NB_COUNT,
  parameter int NB_WINDOW    = DEF_NB_WINDOW,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [NB_WINDOW-1:0]         i_window,
  input  logic [NB_COUNT-1:0]          i_bits_count,
  input  logic [NB_COUNT-1:0]          i_error_count,
  output logic                         o_reset_sinc,
  output logic                         o_enb_rx,
  output logic [NB_PHASE-1:0]          o_phase,
  output logic [NB_COUNT-1:0]          o_best_err,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_fail,
  output logic [N_PHASES*NB_COUNT-1:0] o_phase_err
);

  localparam int                  NB_TIMER   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(LOCK_TIMEOUT - 1);
  localparam logic [NB_TIMER-1:0] TIMER_MAX  = '1;
  localparam logic [NB_COUNT-1:0] ERR_ALL    = '1;
  localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(N_PHASES - 1);

  state_e               state_q, state_d;
  logic [NB_PHASE-1:0]  phase_q, phase_d;
  logic [NB_TIMER-1:0]  timer_q, timer_d;
  logic [NB_WINDOW-1:0] window_q, window_d;
  logic [NB_COUNT-1:0]  phase_err_q, phase_err_d;
  logic                 phase_ok_q, phase_ok_d;
  logic [NB_COUNT-1:0]  best_out_q, best_out_d;

  logic                 trk_clear, trk_valid, any_ok;
  logic [NB_COUNT-1:0]  best_err;
  logic [NB_PHASE-1:0]  best_phase;
  logic                 start_ok, locked, timed_out, window_done;

  assign start_ok    = i_start && ((state_q == IDLE) || (state_q == RUN) || (state_q == FAIL));
  assign locked      = (i_bits_count != '0);
  assign timed_out   = (timer_q == TIMER_LAST);
  assign window_done = (i_bits_count >= NB_COUNT'(window_q));

  // o_phase is phase_q itself, so it only moves on CLEAR entry or out of SELECT,
  // both of which happen while the checker is disabled.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    timer_d     = timer_q;
    window_d    = window_q;
    phase_err_d = phase_err_q;
    phase_ok_d  = phase_ok_q;
    best_out_d  = best_out_q;
    trk_clear   = 1'b0;
    trk_valid   = 1'b0;
    if (i_stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN, FAIL: begin
          if (start_ok) begin
            state_d   = CLEAR;
            phase_d   = '0;
            window_d  = i_window;
            trk_clear = 1'b1;
          end
        end
        CLEAR: begin
          timer_d     = '0;
          phase_ok_d  = 1'b0;
          phase_err_d = ERR_ALL;
          state_d     = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
          if (locked) begin
            state_d = MEASURE;
          end else if (timed_out) begin
            phase_err_d = ERR_ALL;
            phase_ok_d  = 1'b0;
            state_d     = EVAL;
          end
        end
        MEASURE: begin
          if (window_done) begin
            phase_err_d = i_error_count;
            phase_ok_d  = 1'b1;
            state_d     = EVAL;
          end
        end
        EVAL: begin
          trk_valid = phase_ok_q;
          if (phase_q == PHASE_LAST) begin
            state_d = SELECT;
          end else begin
            phase_d = phase_q + 1'b1;
            state_d = CLEAR;
          end
        end
        SELECT: begin
          if (any_ok) begin
            phase_d    = best_phase;
            best_out_d = best_err;
            state_d    = RUN;
          end else begin
            phase_d = '0;
            state_d = FAIL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      timer_q     <= '0;
      window_q    <= '0;
      phase_err_q <= '1;
      phase_ok_q  <= 1'b0;
      best_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      timer_q     <= timer_d;
      window_q    <= window_d;
      phase_err_q <= phase_err_d;
      phase_ok_q  <= phase_ok_d;
      best_out_q  <= best_out_d;
    end
  end

  ber_min_tracker #(
    .NB_PHASE (NB_PHASE),
    .NB_COUNT (NB_COUNT)
  ) u_min_tracker (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_clear      (trk_clear),
    .i_valid      (trk_valid),
    .i_err        (phase_err_q),
    .i_phase      (phase_q),
    .o_best_err   (best_err),
    .o_best_phase (best_phase),
    .o_any_ok     (any_ok)
  );

  assign o_reset_sinc = (state_q == CLEAR) || ((state_q == SELECT) && any_ok);
  assign o_enb_rx     = (state_q == WAIT_LOCK) || (state_q == MEASURE) || (state_q == RUN);
  assign o_phase      = phase_q;
  assign o_best_err   = best_out_q;
  assign o_busy       = is_busy(state_q);
  assign o_done       = (state_q == RUN) || (state_q == FAIL);
  assign o_fail       = (state_q == FAIL);

`ifdef BER_SWEEP_LOG_EN
  logic [N_PHASES*NB_COUNT-1:0] log_q;
  logic                         log_wr;

  assign log_wr = (state_q == EVAL) && !i_stop;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      log_q <= '0;
    end else if (trk_clear) begin
      log_q <= '0;
    end else if (log_wr) begin
      log_q[int'(phase_q)*NB_COUNT +: NB_COUNT] <= phase_err_q;
    end
  end

  assign o_phase_err = log_q;
`else
  assign o_phase_err = '0;
`endif

endmodule

// File: doc/ber_sweep_ctrl.md
Name: ber_sweep_ctrl

Overview:
Sequencer for the PRBS BER checker in the receive path. Sweeps the oversampling phase select across all phases. For each phase it issues a checker sync-reset, waits for checker lock, and measures errors over a programmable bit window. It then selects the phase with the fewest errors and leaves the checker running on that phase.

Parameters:
N_PHASES, 4, number of oversampling phases swept (phase 0 .. N_PHASES-1)
NB_PHASE, 2, width of phase select (clog2 of N_PHASES)
NB_COUNT, 64, width of checker bit/error counters
NB_WINDOW, 32, width of measurement-window length
LOCK_TIMEOUT, 2**20, clock cycles allowed in WAIT_LOCK before a phase is declared failed

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse, starts a sweep
i_stop  in  1  single-cycle pulse, aborts to IDLE from any state
i_window  in  NB_WINDOW  bits measured per phase; sampled on accepted i_start
i_bits_count  in  NB_COUNT  checker bit counter
i_error_count  in  NB_COUNT  checker error counter
o_reset_sinc  out  1  synchronous clear to checker, active-high
o_enb_rx  out  1  checker enable
o_phase  out  NB_PHASE  phase select to sample mux
o_best_err  out  NB_COUNT  error count of selected phase
o_busy  out  1  sweep in progress
o_done  out  1  sweep finished, running on best phase
o_fail  out  1  every phase timed out

Behaviour:
- Reset (i_reset=0): state IDLE; all outputs 0; best_err all-ones internally; timer 0; latched window 0.
- IDLE: o_enb_rx=0, o_reset_sinc=0. i_start -> CLEAR with phase=0, best_err=all-ones, best_phase=0, any_ok=0, window latched.
- CLEAR (1 cycle): o_reset_sinc=1, o_enb_rx=0, timer cleared -> WAIT_LOCK.
- WAIT_LOCK: o_enb_rx=1; timer++ each clock. Lock is detected by i_bits_count != 0 and moves to MEASURE. If timer==LOCK_TIMEOUT-1 with no lock: move to EVAL with phase_err forced to all-ones and phase_ok=0. If lock and timeout occur in the same cycle, lock wins.
- MEASURE: o_enb_rx=1. When i_bits_count >= latched window, snapshot i_error_count into phase_err, set phase_ok=1, and move to EVAL. A window of 0 completes on the first MEASURE cycle.
- EVAL (1 cycle, o_enb_rx=0): if phase_ok and phase_err < best_err (strict), update best_err/best_phase and set any_ok=1. Ties keep the lower phase. If phase==N_PHASES-1, go to SELECT; otherwise phase++ and go to CLEAR.
- SELECT (1 cycle): if any_ok, o_phase=best_phase, o_reset_sinc=1, then RUN. Otherwise go to FAIL.
- RUN: o_enb_rx=1, o_done=1, o_best_err valid and held. i_start restarts the sweep (-> CLEAR, state re-initialised as from IDLE).
- FAIL: o_fail=1, o_done=1, o_enb_rx=0, o_phase=0. i_start restarts.
- o_busy=1 in CLEAR, WAIT_LOCK, MEASURE, EVAL and SELECT.
- i_start while busy is ignored. i_stop has priority over i_start and over all transitions: next state is IDLE, o_done/o_fail cleared, o_best_err held.
- o_phase is registered and changes only on CLEAR entry or in SELECT. The checker never sees a phase change while enabled.
- Error comparison is unsigned over NB_COUNT bits.
- Timer width is clog2(LOCK_TIMEOUT) and it saturates.

Optional Feature:
BER_SWEEP_LOG_EN:
- Defined: adds output o_phase_err [N_PHASES*NB_COUNT-1:0]. Slice k holds phase k's error count, or all-ones if phase k timed out. Slices are written in EVAL, cleared on sweep start, and held after the sweep.
- Undefined: o_phase_err is driven all-zero and no storage is built.

Decomposition:
- Package ber_sweep_pkg: state encoding (IDLE, CLEAR, WAIT_LOCK, MEASURE, EVAL, SELECT, RUN, FAIL), default widths, ERR_MAX all-ones constant.
- One sub-module, ber_min_tracker: holds best_err/best_phase/any_ok with clear, strict-less-than update and tie rule. The top level keeps the FSM, timer and window compare.

Test Plan:
- Errors per phase {40,3,3,17}, window=1000, start -> o_phase=1, o_best_err=3, o_done=1; o_reset_sinc pulsed 5 times total (4 sweep + 1 select).
- Phase 2 never locks (bits_count held 0), LOCK_TIMEOUT=64, others {9,5,x,7} -> timeout after 64 cycles in phase 2; result o_phase=1, o_best_err=5.
- No phase locks -> o_fail=1, o_done=1, o_enb_rx=0, o_phase=0 after 4*64 + overhead cycles.
- i_stop during MEASURE of phase 1 -> IDLE the next cycle, o_busy=0, o_enb_rx=0. i_start during the sweep is ignored; i_start in RUN restarts the sweep at phase 0.
- Async reset asserted mid-WAIT_LOCK -> all outputs 0 immediately, independent of clock. Window=0 -> each phase passes MEASURE in 1 cycle.
- With BER_SWEEP_LOG_EN and errors {40,3,3,17}, LOCK_TIMEOUT such that phase 3 times out -> o_phase_err slices {40,3,3,all-ones}. Without the macro -> o_phase_err=0.
